mem_bus_arbiter: RTL

//  Shares the single-port synchronous system RAM between the cpu6502 core and one DMA requester.
//  CPU is the default owner; DMA steals bounded bursts by dropping cpu ready.

---
 rtl/mem_bus_arbiter_pkg.sv | 21 ++
 rtl/mem_bus_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the system RAM arbiter between the CPU core and the DMA requester.
package mem_bus_arbiter_pkg;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DMA = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DMA = 1'b1
    } owner_e;

    localparam logic [15:0] IO_ADDR_DEFAULT = 16'hbffc;

    // Counter width that stays at least one bit when the count range collapses to a single value.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Single-port RAM arbiter: CPU is the default owner, DMA steals bounded bursts by dropping cpu_ready.
// Also decodes the IO port register address for CPU accesses and muxes the CPU read-return path.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] IO_ADDR   = ADDR_W'(IO_ADDR_DEFAULT),
    parameter int                MAX_BURST = 4,
    parameter int                CPU_MIN   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_addr_next,
    input  logic              cpu_we_next,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_di,
    input  logic [DATA_W-1:0] mem_do,
    output logic              io_we,
    input  logic [DATA_W-1:0] io_rdata
);

    localparam int BURST_W = cnt_w(MAX_BURST);
    localparam int GUARD_W = cnt_w(CPU_MIN + 1);

    arb_state_e          state, state_nxt;
    logic [BURST_W-1:0]  burst_cnt, burst_nxt;
    logic [GUARD_W-1:0]  guard_cnt, guard_nxt;

    logic                owner_dma_p0;
    logic                io_hit_p0;
    logic                burst_last;
    logic                guard_ok;

    owner_e              owner_p1;
    logic                io_hit_p1;
    logic                vld_p1;
    logic [DATA_W-1:0]   rdata_hold;

    // Stage p0: ownership and bus steering for the access happening this cycle
    always_comb begin
        owner_dma_p0 = (state == S_DMA) && dma_req;
        io_hit_p0    = !owner_dma_p0 && (cpu_addr_next == IO_ADDR);

        cpu_ready = !owner_dma_p0;
        dma_gnt   = owner_dma_p0;
        mem_addr  = owner_dma_p0 ? dma_addr  : cpu_addr_next;
        mem_di    = owner_dma_p0 ? dma_wdata : cpu_wdata;
        mem_we    = owner_dma_p0 ? dma_we    : (cpu_we_next && !io_hit_p0);
        io_we     = io_hit_p0 && cpu_we_next;
    end

    assign burst_last = (burst_cnt == BURST_W'(MAX_BURST - 1));
    // Guard of 1 means the current CPU cycle is the last one owed, so DMA may be armed now.
    assign guard_ok   = (guard_cnt <= GUARD_W'(1));

    always_comb begin
        state_nxt = state;
        burst_nxt = burst_cnt;
        guard_nxt = guard_cnt;
        case (state)
            S_CPU: begin
                if (guard_cnt != '0) begin
                    guard_nxt = guard_cnt - GUARD_W'(1);
                end
                if (dma_req && guard_ok) begin
                    state_nxt = S_DMA;
                    burst_nxt = '0;
                end
            end
            S_DMA: begin
                if (owner_dma_p0) begin
                    burst_nxt = burst_cnt + BURST_W'(1);
                end
                if (!dma_req || burst_last) begin
                    state_nxt = S_CPU;
                    guard_nxt = GUARD_W'(CPU_MIN);
                end
            end
            default: begin
                state_nxt = S_CPU;
            end
        endcase
    end

    // Stage p1: register who owned the access so the RAM's 1-cycle read data is routed back
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_CPU;
            burst_cnt  <= '0;
            guard_cnt  <= '0;
            owner_p1   <= OWN_CPU;
            io_hit_p1  <= 1'b0;
            vld_p1     <= 1'b0;
            rdata_hold <= '0;
        end else begin
            state     <= state_nxt;
            burst_cnt <= burst_nxt;
            guard_cnt <= guard_nxt;
            owner_p1  <= owner_dma_p0 ? OWN_DMA : OWN_CPU;
            io_hit_p1 <= io_hit_p0;
            vld_p1    <= owner_dma_p0 && !dma_we;
            if (owner_p1 == OWN_CPU) begin
                rdata_hold <= cpu_rdata;
            end
        end
    end

    // CPU sees fresh data after its own slot and the held value across DMA-stolen cycles.
    always_comb begin
        if (owner_p1 == OWN_CPU) begin
            cpu_rdata = io_hit_p1 ? io_rdata : mem_do;
        end else begin
            cpu_rdata = rdata_hold;
        end
        dma_rvalid = vld_p1;
        dma_rdata  = mem_do;
    end

endmodule
